// File: rtl/req_responder.sv
// Round-robin request responder: grants one requesting channel at a time,
// forwards its payload downstream with a valid/ready handshake, then pulses that channel's ack.
module req_responder #(
    parameter int  N_REQ  = 4,
    parameter int  DATA_W = 64,
    localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              blk_q, blk_d;

    logic [N_REQ-1:0]  elig;
    logic [DATA_W-1:0] ch_data [N_REQ];
    logic              found;
    logic [SRC_W-1:0]  pick;
    logic [SRC_W:0]    idx;

    // The channel just acked still holds req for one more cycle, so it is masked
    // out (blk_q) during the first idle cycle to avoid serving it twice.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ch
            assign ch_data[gi] = req_data[gi*DATA_W +: DATA_W];
            assign elig[gi]    = req[gi] & ~(blk_q & (out_src_q == SRC_W'(gi)));
            assign ack[gi]     = (state_q == S_ACK) && (out_src_q == SRC_W'(gi));
        end
    endgenerate

    // Scan channels starting at ptr_q; the first eligible one wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
            if (idx >= (SRC_W+1)'(N_REQ)) begin
                idx = idx - (SRC_W+1)'(N_REQ);
            end
            if (!found && elig[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_src_d  = out_src_q;
        out_data_d = out_data_q;
        blk_d      = blk_q;
        case (state_q)
            S_IDLE: begin
                blk_d = 1'b0;
                if (found) begin
                    out_src_d  = pick;
                    out_data_d = ch_data[pick];
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                blk_d   = 1'b1;
                ptr_d   = (out_src_q == SRC_W'(N_REQ-1)) ? '0 : out_src_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            out_src_q  <= '0;
            out_data_q <= '0;
            blk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_src_q  <= out_src_d;
            out_data_q <= out_data_d;
            blk_q      <= blk_d;
        end
    end

    assign out_valid = (state_q == S_SEND);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_req_responder.sv
// Directed and randomized checks of req_responder against a transaction-timing reference model;
// requesters hold req until ack and drop it two cycles after seeing ack.
module tb_req_responder;

    localparam int N  = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  ack;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic          out_ready;

    always #5 clk = ~clk;

    req_responder #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: one transfer at a time, tracked by the cycle numbers of its events.
    bit            m_busy;
    int            m_ack_at;
    int            m_free_at;
    int            m_ptr;
    int            m_blk_ch;
    int            m_blk_at;
    int            m_src;
    logic [DW-1:0] m_data;

    int  drop_at [N];
    bit  rand_req = 1'b0;
    int  obs_ch [$];
    int  obs_cyc [$];
    int  served [N];
    bit  reraised;

    task automatic chk(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Predicts what the inputs presented during cycle cyc cause in cycle cyc+1.
    task automatic model_step();
        if (reset) begin
            m_busy    = 1'b0;
            m_ack_at  = -1;
            m_free_at = cyc + 1;
            m_ptr     = 0;
            m_blk_ch  = -1;
            m_blk_at  = -1;
            m_src     = 0;
            m_data    = '0;
        end else if (m_busy && m_ack_at == cyc) begin
            m_busy    = 1'b0;
            m_ack_at  = -1;
            m_ptr     = (m_src + 1) % N;
            m_blk_ch  = m_src;
            m_blk_at  = cyc + 1;
            m_free_at = cyc + 1;
        end else if (m_busy && m_ack_at < 0) begin
            if (out_ready) m_ack_at = cyc + 1;
        end else if (!m_busy && cyc >= m_free_at) begin
            for (int k = 0; k < N; k++) begin
                int ch = (m_ptr + k) % N;
                if (req[ch] && !(cyc == m_blk_at && ch == m_blk_ch)) begin
                    m_busy = 1'b1;
                    m_src  = ch;
                    m_data = req_data[ch*DW +: DW];
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_ack;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        exp_ack = (m_busy && m_ack_at == cyc) ? N'(1 << m_src) : '0;
        chk("out_valid", out_valid, (m_busy && m_ack_at < 0));
        chk("ack", ack, exp_ack);
        chk("out_src", out_src, m_src);
        chk("out_data", out_data, m_data);
        chk("ack_onehot", ($countones(ack) <= 1), 1);
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                obs_ch.push_back(i);
                obs_cyc.push_back(cyc);
                served[i]++;
                drop_at[i] = cyc + 2;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (drop_at[i] == cyc) req[i] = 1'b0;
        end
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && drop_at[i] != cyc && $urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = {$urandom, $urandom};
                end
            end
        end
    endtask

    task automatic clear_obs();
        obs_ch.delete();
        obs_cyc.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            drop_at[i] = -1;
            served[i]  = 0;
        end
        m_busy = 1'b0; m_ack_at = -1; m_free_at = 0; m_ptr = 0;
        m_blk_ch = -1; m_blk_at = -1; m_src = 0; m_data = '0;

        // Reset overrides requests and ready.
        reset = 1'b1; req = 4'b1111; req_data = '1; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ack", ack, 0);
        chk("rst_src", out_src, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b0; req = '0; req_data = '0;
        tick();

        // Single channel: latency and payload.
        req_data[2*DW +: DW] = 64'hA5; req = 4'b0100; out_ready = 1'b1;
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 64'hA5);
        chk("single_src", out_src, 2);
        chk("single_noack", ack, 0);
        tick();
        chk("single_ack", ack, 4'b0100);
        chk("single_valid_off", out_valid, 0);
        tick();
        chk("single_ack_once", ack, 0);
        tick();
        chk("single_no_regrant", out_valid, 0);
        tick();

        // Backpressure on channel 0 (pointer is 3 here).
        req_data[0 +: DW] = 64'h1234_5678_9ABC_DEF0; req = 4'b0001; out_ready = 1'b0;
        tick();
        chk("bp_valid0", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 64'h1234_5678_9ABC_DEF0);
            chk("bp_noack", ack, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_ack", ack, 4'b0001);
        tick();
        tick();

        // Fairness from pointer 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_obs();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 64'(100 + i);
        req = 4'b1111; out_ready = 1'b1;
        repeat (14) tick();
        chk("fair_count", obs_ch.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (obs_ch.size() > i) chk("fair_order", obs_ch[i], i);
            if (i > 0 && obs_cyc.size() > i) chk("fair_spacing", obs_cyc[i] - obs_cyc[i-1], 3);
        end

        // Wrap: channel 3 was served last, so 0 goes before 3.
        clear_obs();
        req = 4'b1001;
        repeat (9) tick();
        chk("wrap_count", obs_ch.size(), 2);
        if (obs_ch.size() >= 2) begin
            chk("wrap_first", obs_ch[0], 0);
            chk("wrap_second", obs_ch[1], 3);
        end

        // Blackout: channel 1 still requesting in the idle cycle, channel 2 wins it.
        clear_obs();
        req_data[1*DW +: DW] = 64'h11; req = 4'b0010;
        tick();
        req_data[2*DW +: DW] = 64'h22; req[2] = 1'b1;
        repeat (9) tick();
        chk("blk_count", obs_ch.size(), 2);
        if (obs_ch.size() >= 2) begin
            chk("blk_first", obs_ch[0], 1);
            chk("blk_second", obs_ch[1], 2);
            chk("blk_spacing", obs_cyc[1] - obs_cyc[0], 3);
        end

        // Requester drops req while granted: transfer still completes.
        req_data[2*DW +: DW] = 64'hDEAD; req = 4'b0100; out_ready = 1'b0;
        tick();
        chk("drop_valid", out_valid, 1);
        req[2] = 1'b0;
        tick();
        chk("drop_hold", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("drop_ack", ack, 4'b0100);
        tick();
        tick();

        // Reset during SEND abandons the transfer; held req[3] is granted afterwards.
        req_data[3*DW +: DW] = 64'h33; req = 4'b1000; out_ready = 1'b0;
        tick();
        chk("rsend_valid", out_valid, 1);
        reset = 1'b1;
        tick();
        chk("rsend_valid_off", out_valid, 0);
        chk("rsend_ack", ack, 0);
        chk("rsend_src", out_src, 0);
        reset = 1'b0;
        tick();
        chk("rsend_regrant", out_valid, 1);
        chk("rsend_src3", out_src, 3);
        out_ready = 1'b1;
        tick();
        chk("rsend_ack3", ack, 4'b1000);
        tick();
        tick();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < N; i++) served[i] = 0;
        reraised = 1'b0;
        rand_req = 1'b1;
        repeat (400) begin
            out_ready = ($urandom_range(9) < 7);
            tick();
        end
        rand_req = 1'b0;
        out_ready = 1'b1;
        repeat (30) tick();
        for (int i = 0; i < N; i++) chk("rand_served", (served[i] > 0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/req_responder.md
REQ_RESPONDER -- requirements
Module: req_responder

Interface
REQ-001 Parameter N_REQ, default 4, number of request channels (2..16).
REQ-002 Parameter DATA_W, default 64, payload width per channel.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req  input  N_REQ  per-channel request level, held by requester until its ack is sampled.
REQ-006 Port req_data  input  N_REQ*DATA_W  per-channel payload, channel i at bits [i*DATA_W +: DATA_W], stable while req[i] high.
REQ-007 Port ack  output  N_REQ  per-channel one-cycle acknowledge pulse.
REQ-008 Port out_valid  output  1  downstream payload valid.
REQ-009 Port out_data  output  DATA_W  registered payload of granted channel.
REQ-010 Port out_src  output  clog2(N_REQ)  index of granted channel.
REQ-011 Port out_ready  input  1  downstream accepts when out_valid and out_ready both high.

Function
REQ-012 The block SHALL be a three-state FSM: IDLE, SEND, ACK.
REQ-013 IDLE: when any eligible req bit is high, SHALL grant one channel by round-robin starting at priority pointer ptr, register req_data and index into out_data/out_src, and move to SEND.
REQ-014 IDLE with no eligible req SHALL hold state; out_data/out_src retain last values.
REQ-015 SEND: out_valid SHALL be 1; out_data/out_src SHALL stay stable until handshake.
REQ-016 SEND with out_ready=1 SHALL complete transfer and move to ACK; with out_ready=0 SHALL hold indefinitely.
REQ-017 ACK: ack[out_src] SHALL be 1 for exactly that one cycle, all other ack bits 0; out_valid SHALL be 0; next state IDLE.
REQ-018 On leaving ACK, ptr SHALL become out_src+1, wrapping N_REQ-1 -> 0.
REQ-019 In the first IDLE cycle after ACK the just-acked channel SHALL be ineligible (requester drops req one cycle after ack); all other channels eligible.
REQ-020 ack and out_valid SHALL be decoded from registered state only; no combinational path from req/out_ready to ack or out_valid.
REQ-021 Latency: req high in cycle T (IDLE) -> out_valid in T+1 -> with out_ready high, ack in T+2 -> next grant decision earliest T+3.
REQ-022 Simultaneous requests SHALL be served in round-robin order; no channel starves while out_ready eventually asserts.
REQ-023 req[i] deasserting while channel i is granted (protocol violation) SHALL NOT abort: transfer completes and ack[i] still pulses.
REQ-024 Requests arriving on other channels during SEND/ACK SHALL wait; no request is lost while held.
REQ-025 At most one ack bit SHALL be high in any cycle; at most one transfer outstanding.

Reset
REQ-026 reset high at a clock edge SHALL force state IDLE, ptr 0, ack all 0, out_valid 0, out_data 0, out_src 0, next cycle, overriding all other inputs.
REQ-027 Reset during SEND or ACK SHALL abandon the transfer with no ack pulse; first grant after reset uses ptr 0.

Verification
REQ-028 Single channel: N_REQ=4, req=0b0100, data2=0xA5, out_ready=1 -> out_valid cycle+1 with out_data=0xA5, out_src=2; ack=0b0100 cycle+2 only.
REQ-029 Backpressure: req[0] high, out_ready low 5 cycles -> out_valid held 5 cycles with stable data, no ack; out_ready high -> ack[0] next cycle.
REQ-030 Fairness: req=0b1111 held, each dropped one cycle after its ack, out_ready=1 -> grant order 0,1,2,3; each ack exactly one cycle, 3-cycle spacing.
REQ-031 Wrap: after serving channel 3 with req=0b1001 pending -> next grant is 0, then 3.
REQ-032 Blackout: req[1] left high through ack and following cycle with req[2] high -> channel 2 granted next, channel 1 not double-served in that cycle.
REQ-033 Reset in SEND: reset pulse while out_valid=1 -> out_valid 0, ack 0, out_src 0 next cycle; held req[3] granted afterwards with ptr 0.
